decimal32_encode_arbiter: RTL and testbench
===========================================

# decimal32_encode_arbiter

Shares one decimal32 encoder between the adder and subtractor result paths of the decimal unit. Each path offers a sign, 8-bit exponent and 7-digit BCD significand through a valid/ready handshake. A round-robin arbiter grants one path per cycle, packs the operand into the 32-bit interchange word (DPD declets plus combination field), and holds it in an output register behind a valid/ready handshake. It sits between the arithmetic cores and the result writeback / output bus.

## Interface
- No parameters.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  adder path offers an operand
- a_ready  out  1  adder operand accepted this cycle
- a_s  in  1  adder sign
- a_e  in  8  adder exponent
- a_m  in  28  adder significand, 7 BCD digits, digit 6 in [27:24]
- s_valid, s_ready, s_s, s_e, s_m: subtractor path; same widths and meaning as the adder path
- out_valid  out  1  out_result holds a packed word
- out_ready  in  1  consumer takes the word
- out_result  out  32  packed decimal32 word
- out_src  out  1  source of the word: 0 = adder, 1 = subtractor
- out_err  out  1  at least one significand nibble of the word's operand was greater than 9

## Operation
- The output register is a single entry. `load = !out_valid || out_ready`.
- Grant when `load` is high:
  - If only one path is valid, that path is granted.
  - If both are valid, the path that was not granted last is granted (round-robin).
  - `last` resets to 1, so the adder wins the first tie.
- `a_ready` / `s_ready` are high only in the granted cycle. They are combinational from the valids, `out_ready` and the state. Ready never asserts without the matching valid.
- On a grant: the output register captures `pack(sign, exp, sig)`, `out_src`, `out_err`; `out_valid` is set to 1; `last` is set to the granted source.
- If `out_valid && out_ready` and nothing is granted, `out_valid` is cleared to 0.
- Packing is performed by the sub-module and is purely combinational:
  - result[9:0] = DPD encoding of digits 2..0.
  - result[19:10] = DPD encoding of digits 5..3.
  - DPD cases follow the 8-case table keyed on which digits are greater than 7. When all three digits are large, the top two bits are 00.
  - result[30:26] = combination field C:
    - digit 6 ≤ 7: C = {e[7:6], d6[2:0]}.
    - digit 6 > 7: C = {2'b11, e[7:6], d6[0]}.
    - e[7:6] = 11 (special value): C = 11110.
  - result[25:20] = e[5:0]; for the special value it is 6'b111111.
  - result[31] = sign.
- Nibbles greater than 9 are still packed per the table. Only `out_err` flags them.

## Timing
- Reset values: `out_valid` = 0, `out_result` = 0, `out_src` = 0, `out_err` = 0, `last` = 1, both readies = 0. Reset overrides any grant in the same cycle.
- Latency: an operand accepted at edge N appears on `out_*` after edge N. That gives 1 cycle latency.
- Throughput: 1 word per cycle while `out_ready` is held high.
- Stall: while `out_valid && !out_ready`, no grant occurs and `out_*` is held stable.
- Requesters must hold their operand stable until ready.
- Simultaneous drain and accept: the new word replaces the old one in the same edge, with no bubble.
- Reset mid-transfer: the held word is discarded and no ready is issued.

## Structure
Shared package `decimal32_pkg` holds:
- Constants: COMB_SPECIAL = 5'b11110, EXP_SPECIAL_LO = 6'b111111, SRC_ADD = 0, SRC_SUB = 1.
- A function for the 3-digit DPD declet.

Sub-module `decimal32_packer` is the combinational packer: s, e, m in; result[31:0] and err out. The arbiter, the output register and `last` stay in the top level.

## Test plan
- Single packing: a_s = 0, a_e = 8'h00, a_m = 28'h0000123; out_ready = 1.
  - Required: out_result = 32'h000000A3, out_src = 0, out_err = 0, one cycle after acceptance.
- Large leading digit: s_m = 28'h9000000, s_e = 8'h41, s_s = 0.
  - Required: out_result = 32'h6C100000, out_src = 1.
- Special exponent: a_s = 1, a_e = 8'hC0, a_m = 0.
  - Required: out_result = 32'hFBF00000.
- Fairness: both paths valid continuously with out_ready = 1.
  - Required: grants alternate adder, subtractor, adder, …; adder first after reset.
  - Required: exactly one ready per cycle; the out_src sequence is 0,1,0,1.
- Backpressure: out_ready = 0 for 5 cycles with both paths valid.
  - Required: out_* constant and both readies low during the stall.
  - Required: when out_ready rises, the next word is loaded in the same cycle.
- Error flag and reset: a_m = 28'h000000A.
  - Required: out_err = 1.
  - Asserting rst while out_valid = 1 must yield out_valid = 0 and out_result = 0 on the next edge.

Source files
------------

// File: rtl/decimal32_pkg.sv
// decimal32_pkg
//   Shared constants and the 3-digit BCD -> DPD declet helper used by the
//   decimal32 packer and the encode arbiter.
package decimal32_pkg;

  localparam logic [4:0] COMB_SPECIAL   = 5'b11110;
  localparam logic [5:0] EXP_SPECIAL_LO = 6'b111111;
  localparam logic       SRC_ADD        = 1'b0;
  localparam logic       SRC_SUB        = 1'b1;

  // Densely-packed-decimal encoding of three BCD digits {d2, d1, d0}.
  // The case key is the "large digit" bit (bit 3) of each digit; nibbles
  // above 9 still follow the table through that bit.
  function automatic logic [9:0] dpd_encode(input logic [11:0] bcd);
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    logic [9:0] r;
    d2 = bcd[11:8];
    d1 = bcd[7:4];
    d0 = bcd[3:0];
    case ({d2[3], d1[3], d0[3]})
      3'b000:  r = {d2[2:0], d1[2:0], 1'b0, d0[2:0]};
      3'b001:  r = {d2[2:0], d1[2:0], 1'b1, 2'b00, d0[0]};
      3'b010:  r = {d2[2:0], d0[2:1], d1[0], 1'b1, 2'b01, d0[0]};
      3'b011:  r = {d2[2:0], 2'b10, d1[0], 1'b1, 2'b11, d0[0]};
      3'b100:  r = {d0[2:1], d2[0], d1[2:0], 1'b1, 2'b10, d0[0]};
      3'b101:  r = {d1[2:1], d2[0], 2'b01, d1[0], 1'b1, 2'b11, d0[0]};
      3'b110:  r = {d0[2:1], d2[0], 2'b00, d1[0], 1'b1, 2'b11, d0[0]};
      3'b111:  r = {2'b00, d2[0], 2'b11, d1[0], 1'b1, 2'b11, d0[0]};
      default: r = 10'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decimal32_packer.sv
// decimal32_packer
//   Combinational packer: sign, 8-bit exponent and 7-digit BCD significand
//   into a 32-bit decimal32 interchange word.
//   Ports:
//     s       in  1   sign
//     e       in  8   exponent
//     m       in  28  significand, digit 6 in [27:24]
//     result  out 32  packed word
//     err     out 1   some significand nibble is greater than 9
module decimal32_packer
  import decimal32_pkg::*;
(
  input  logic        s,
  input  logic [7:0]  e,
  input  logic [27:0] m,
  output logic [31:0] result,
  output logic        err
);

  logic [4:0] comb_s;
  logic [5:0] exp_lo_s;
  logic       err_s;

  // Combination field and low exponent bits; the special exponent wins
  // over the large-leading-digit form.
  always_comb begin
    comb_s   = 5'd0;
    exp_lo_s = 6'd0;
    if (e[7:6] == 2'b11) begin
      comb_s   = COMB_SPECIAL;
      exp_lo_s = EXP_SPECIAL_LO;
    end else if (m[27]) begin
      comb_s   = {2'b11, e[7:6], m[24]};
      exp_lo_s = e[5:0];
    end else begin
      comb_s   = {e[7:6], m[26:24]};
      exp_lo_s = e[5:0];
    end
  end

  // Flag any non-decimal nibble in the significand.
  always_comb begin
    err_s = 1'b0;
    for (int i = 0; i < 7; i++) begin
      err_s = err_s | (m[i*4 +: 4] > 4'd9);
    end
  end

  assign result = {s, comb_s, exp_lo_s, dpd_encode(m[23:12]), dpd_encode(m[11:0])};
  assign err    = err_s;

endmodule

// File: rtl/decimal32_encode_arbiter.sv
// decimal32_encode_arbiter
//   Round-robin arbiter sharing one decimal32 packer between the adder (a_*)
//   and subtractor (s_*) result paths, with a single-entry output register.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     a_valid/a_ready          adder handshake; a_s, a_e, a_m operand
//     s_valid/s_ready          subtractor handshake; s_s, s_e, s_m operand
//     out_valid/out_ready      output handshake
//     out_result               packed decimal32 word
//     out_src                  0 = adder, 1 = subtractor
//     out_err                  operand had a nibble greater than 9
module decimal32_encode_arbiter
  import decimal32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic        a_s,
  input  logic [7:0]  a_e,
  input  logic [27:0] a_m,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_s,
  input  logic [7:0]  s_e,
  input  logic [27:0] s_m,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_src,
  output logic        out_err
);

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_result_q, out_result_d;
  logic        out_src_q, out_src_d;
  logic        out_err_q, out_err_d;
  logic        last_q, last_d;

  logic        load_s;
  logic        grant_a_s;
  logic        grant_s_s;
  logic        sel_s_s;
  logic [7:0]  sel_e_s;
  logic [27:0] sel_m_s;
  logic [31:0] pack_result_s;
  logic        pack_err_s;

  // Grant decision: a tie goes to the path not granted last; reset blocks
  // every grant so no ready is issued while rst is high.
  always_comb begin
    load_s    = !out_valid_q || out_ready;
    grant_a_s = !rst && load_s && a_valid && (!s_valid || (last_q == SRC_SUB));
    grant_s_s = !rst && load_s && s_valid && (!a_valid || (last_q == SRC_ADD));
  end

  // Operand mux in front of the shared packer.
  always_comb begin
    if (grant_s_s) begin
      sel_s_s = s_s;
      sel_e_s = s_e;
      sel_m_s = s_m;
    end else begin
      sel_s_s = a_s;
      sel_e_s = a_e;
      sel_m_s = a_m;
    end
  end

  decimal32_packer u_packer (
    .s      (sel_s_s),
    .e      (sel_e_s),
    .m      (sel_m_s),
    .result (pack_result_s),
    .err    (pack_err_s)
  );

  // Next state of the output register and round-robin pointer.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_src_d    = out_src_q;
    out_err_d    = out_err_q;
    last_d       = last_q;
    if (grant_a_s || grant_s_s) begin
      out_valid_d  = 1'b1;
      out_result_d = pack_result_s;
      out_src_d    = grant_s_s ? SRC_SUB : SRC_ADD;
      out_err_d    = pack_err_s;
      last_d       = grant_s_s ? SRC_SUB : SRC_ADD;
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
    end else begin
      out_valid_d  = out_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= 32'd0;
      out_src_q    <= 1'b0;
      out_err_q    <= 1'b0;
      last_q       <= SRC_SUB;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_src_q    <= out_src_d;
      out_err_q    <= out_err_d;
      last_q       <= last_d;
    end
  end

  assign a_ready    = grant_a_s;
  assign s_ready    = grant_s_s;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_src    = out_src_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_decimal32_encode_arbiter.sv
// tb_decimal32_encode_arbiter
//   Scoreboard bench: the expected packed word is pushed when the bench's
//   own arbitration model predicts a grant and popped after the edge.
module tb_decimal32_encode_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, a_s;
  logic [7:0]  a_e;
  logic [27:0] a_m;
  logic        s_valid, s_ready, s_s;
  logic [7:0]  s_e;
  logic [27:0] s_m;
  logic        out_valid, out_ready, out_src, out_err;
  logic [31:0] out_result;

  int n_tests = 0;
  int n_fail  = 0;

  // Bench model state.
  logic        m_valid = 1'b0;
  logic        m_last  = 1'b1;
  logic [33:0] m_hold  = 34'd0;  // {src, err, result}
  logic [33:0] sb_q[$];
  logic        g_a, g_s;

  decimal32_encode_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_s(a_s), .a_e(a_e), .a_m(a_m),
    .s_valid(s_valid), .s_ready(s_ready), .s_s(s_s), .s_e(s_e), .s_m(s_m),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_src(out_src), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // DPD written as sum-of-products equations, independent of the table form.
  function automatic logic [9:0] ref_dpd(input logic [11:0] d);
    logic a, b, c, dd, e, f, g, h, i, j, k, m;
    logic p, q, s5, t, v, w, x;
    {a, b, c, dd} = d[11:8];
    {e, f, g, h}  = d[7:4];
    {i, j, k, m}  = d[3:0];
    p  = (!a & b) | (a & !i & j) | (a & !e & i & f);
    q  = (!a & c) | (a & !i & k) | (a & !e & i & g);
    s5 = (!e & !(a & i) & f) | (e & i) | (!a & e & !i & j);
    t  = (!e & !(a & i) & g) | (a & i) | (!a & e & !i & k);
    v  = a | e | i;
    w  = a | (e & i) | (!e & !i & j);
    x  = (!a & !e & !i & k) | e | (a & i);
    return {p, q, dd, s5, t, h, v, w, x, m};
  endfunction

  function automatic logic [33:0] ref_pack(input logic sg, input logic [7:0] ex,
                                           input logic [27:0] mm, input logic src);
    logic [4:0] cf;
    logic [5:0] el;
    logic       er;
    if (ex[7:6] == 2'b11) begin
      cf = 5'b11110; el = 6'b111111;
    end else if (mm[27:24] > 4'd7) begin
      cf = {2'b11, ex[7:6], mm[24]}; el = ex[5:0];
    end else begin
      cf = {ex[7:6], mm[26:24]}; el = ex[5:0];
    end
    er = 1'b0;
    for (int n = 0; n < 7; n++) if (mm[n*4 +: 4] > 4'd9) er = 1'b1;
    return {src, er, sg, cf, el, ref_dpd(mm[23:12]), ref_dpd(mm[11:0])};
  endfunction

  function automatic logic [27:0] rand_sig();
    logic [27:0] r;
    for (int n = 0; n < 7; n++) r[n*4 +: 4] = 4'($urandom_range(0, 11));
    return r;
  endfunction

  // One clock: predict and check readies at negedge, check outputs after edge.
  task automatic cycle();
    logic ld, drain;
    logic [33:0] it;
    @(negedge clk);
    ld  = !m_valid || out_ready;
    g_a = !rst && ld && a_valid && (!s_valid || m_last);
    g_s = !rst && ld && s_valid && (!a_valid || !m_last);
    drain = m_valid && out_ready;
    check_eq("a_ready", 32'(a_ready), 32'(g_a));
    check_eq("s_ready", 32'(s_ready), 32'(g_s));
    if (g_a) sb_q.push_back(ref_pack(a_s, a_e, a_m, 1'b0));
    if (g_s) sb_q.push_back(ref_pack(s_s, s_e, s_m, 1'b1));
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 1'b0; m_last = 1'b1; m_hold = 34'd0; sb_q.delete();
      check_eq("rst_valid",  32'(out_valid), 32'd0);
      check_eq("rst_result", out_result, 32'd0);
      check_eq("rst_src",    32'(out_src), 32'd0);
      check_eq("rst_err",    32'(out_err), 32'd0);
    end else if (g_a || g_s) begin
      it = sb_q.pop_front();
      m_valid = 1'b1; m_last = g_s; m_hold = it;
      check_eq("valid",  32'(out_valid), 32'd1);
      check_eq("result", out_result, it[31:0]);
      check_eq("src",    32'(out_src), 32'(it[33]));
      check_eq("err",    32'(out_err), 32'(it[32]));
    end else begin
      if (drain) m_valid = 1'b0;
      check_eq("idle_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        check_eq("hold_result", out_result, m_hold[31:0]);
        check_eq("hold_src",    32'(out_src), 32'(m_hold[33]));
        check_eq("hold_err",    32'(out_err), 32'(m_hold[32]));
      end
    end
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    a_valid = 1'b0; a_s = 1'b0; a_e = 8'h00; a_m = 28'h0;
    s_valid = 1'b0; s_s = 1'b0; s_e = 8'h00; s_m = 28'h0;
    cycle(); cycle();
    rst = 1'b0;

    // Single packing.
    a_valid = 1'b1; a_s = 1'b0; a_e = 8'h00; a_m = 28'h0000123;
    cycle();
    check_eq("pack123", out_result, 32'h000000A3);
    check_eq("pack123_src", 32'(out_src), 32'd0);
    a_valid = 1'b0;
    cycle();

    // Large leading digit.
    s_valid = 1'b1; s_s = 1'b0; s_e = 8'h41; s_m = 28'h9000000;
    cycle();
    check_eq("large_lead", out_result, 32'h6C100000);
    check_eq("large_lead_src", 32'(out_src), 32'd1);
    s_valid = 1'b0;

    // Special exponent.
    a_valid = 1'b1; a_s = 1'b1; a_e = 8'hC0; a_m = 28'h0;
    cycle();
    check_eq("special", out_result, 32'hFBF00000);
    a_valid = 1'b0;

    // Fairness right after reset: adder first, then alternate.
    rst = 1'b1; cycle(); rst = 1'b0;
    a_valid = 1'b1; s_valid = 1'b1;
    for (int n = 0; n < 6; n++) begin
      cycle();
      check_eq("fair_src", 32'(out_src), 32'(n % 2));
      check_eq("fair_one_ready", 32'(g_a) + 32'(g_s), 32'd1);
      if (g_a) begin a_s = 1'($urandom); a_e = 8'($urandom); a_m = rand_sig(); end
      if (g_s) begin s_s = 1'($urandom); s_e = 8'($urandom); s_m = rand_sig(); end
    end

    // Backpressure: 5 stalled cycles, then a load on the resume edge.
    out_ready = 1'b0;
    for (int n = 0; n < 5; n++) cycle();
    out_ready = 1'b1;
    cycle();
    check_eq("bp_resume_grant", 32'(a_ready | s_ready | g_a | g_s), 32'd1);

    // Randomised traffic with random backpressure.
    for (int n = 0; n < 300; n++) begin
      if (g_a || !a_valid) begin
        a_valid = 1'($urandom); a_s = 1'($urandom); a_e = 8'($urandom); a_m = rand_sig();
      end
      if (g_s || !s_valid) begin
        s_valid = 1'($urandom); s_s = 1'($urandom); s_e = 8'($urandom); s_m = rand_sig();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Error flag.
    a_valid = 1'b0; s_valid = 1'b0; out_ready = 1'b1;
    cycle(); cycle();
    a_valid = 1'b1; a_s = 1'b0; a_e = 8'h00; a_m = 28'h000000A;
    cycle();
    check_eq("err_flag", 32'(out_err), 32'd1);
    a_valid = 1'b0; out_ready = 1'b0;
    cycle();

    // Reset while a word is held and a request is pending.
    a_valid = 1'b1; a_m = 28'h0000456; out_ready = 1'b1;
    rst = 1'b1;
    cycle();
    check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
    check_eq("rst_mid_result", out_result, 32'd0);
    rst = 1'b0; a_valid = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
